uart_echo_engine: RTL and testbench

//  Consumer stage between the uart block's rx FIFO read port and its tx FIFO write port.

---
 rtl/uart_echo_engine.sv | 107 ++++++++++
 tb/tb_uart_echo_engine.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_engine.sv
// Echo data path between the uart rx FIFO read port and tx FIFO write port.
// Pops one word at a time, optionally upper-cases it or expands CR to CR+LF, and counts pushes.
module uart_echo_engine #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CRLF_EXPAND = 1,
  parameter int unsigned UPPERCASE   = 0,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_empty,
  output logic                   rx_read,
  output logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_full,
  output logic                   tx_write,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] echo_count
);

  localparam logic [DATA_WIDTH-1:0] CharCr   = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CharLf   = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CharLowA = DATA_WIDTH'(8'h61);
  localparam logic [DATA_WIDTH-1:0] CharLowZ = DATA_WIDTH'(8'h7A);
  localparam logic [DATA_WIDTH-1:0] CaseDiff = DATA_WIDTH'(8'h20);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StWr,
    StWrWait,
    StWrWaitLf,
    StLf
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic                    cr_q;

  function automatic logic [DATA_WIDTH-1:0] transform(input logic [DATA_WIDTH-1:0] w);
    if (UPPERCASE != 0 && w >= CharLowA && w <= CharLowZ) begin
      return w - CaseDiff;
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_q     <= '0;
      cr_q       <= 1'b0;
      rx_read    <= 1'b0;
      tx_write   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      echo_count <= '0;
    end else begin
      rx_read  <= 1'b0;
      tx_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable && !rx_empty) begin
            word_q  <= rx_data;
            rx_read <= 1'b1;
            busy    <= 1'b1;
            state_q <= StPop;
          end
        end
        StPop: begin
          // CR detection uses the raw word, before any transform.
          cr_q    <= (CRLF_EXPAND != 0) && (word_q == CharCr);
          word_q  <= transform(word_q);
          state_q <= StWr;
        end
        StWr: begin
          if (!tx_full) begin
            tx_write <= 1'b1;
            tx_data  <= word_q;
            state_q  <= cr_q ? StWrWaitLf : StWrWait;
          end
        end
        StWrWait: begin
          if (echo_count != '1) echo_count <= echo_count + COUNT_WIDTH'(1);
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StWrWaitLf: begin
          if (echo_count != '1) echo_count <= echo_count + COUNT_WIDTH'(1);
          state_q <= StLf;
        end
        StLf: begin
          if (!tx_full) begin
            tx_write <= 1'b1;
            tx_data  <= CharLf;
            state_q  <= StWrWait;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_engine.sv
// Bench for uart_echo_engine: two instances with different parameters, queue-based FIFO models
// and a word-level reference model of the echo transforms.
module tb_uart_echo_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    = 1'b1;
  logic        enable   = 1'b1;
  logic        tx_full_a = 1'b0;
  logic        tx_full_b = 1'b0;
  logic        rx_empty_a = 1'b1;
  logic        rx_empty_b = 1'b1;
  logic [7:0]  rx_data_a = 8'h00;
  logic [7:0]  rx_data_b = 8'h00;
  logic        rx_read_a, rx_read_b, tx_write_a, tx_write_b, busy_a, busy_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic [15:0] echo_count_a;
  logic [2:0]  echo_count_b;

  // dut_a: CR expansion and upper-casing on; dut_b: plain echo with a 3-bit counter.
  uart_echo_engine #(
    .DATA_WIDTH (8),
    .CRLF_EXPAND(1),
    .UPPERCASE  (1),
    .COUNT_WIDTH(16)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rx_data   (rx_data_a),
    .rx_empty  (rx_empty_a),
    .rx_read   (rx_read_a),
    .tx_data   (tx_data_a),
    .tx_full   (tx_full_a),
    .tx_write  (tx_write_a),
    .busy      (busy_a),
    .echo_count(echo_count_a)
  );

  uart_echo_engine #(
    .DATA_WIDTH (8),
    .CRLF_EXPAND(0),
    .UPPERCASE  (0),
    .COUNT_WIDTH(3)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rx_data   (rx_data_b),
    .rx_empty  (rx_empty_b),
    .rx_read   (rx_read_b),
    .tx_data   (tx_data_b),
    .tx_full   (tx_full_b),
    .tx_write  (tx_write_b),
    .busy      (busy_b),
    .echo_count(echo_count_b)
  );

  logic [7:0] rxq_a[$], rxq_b[$], txq_a[$], txq_b[$], exp_q[$];
  int         rdc_a[$], wrc_a[$];
  int         cyc = 0;
  int         rd_cnt_a = 0, rd_cnt_b = 0, b2b_err = 0;
  logic       prev_wr_a = 1'b0, prev_rd_a = 1'b0, prev_wr_b = 1'b0, prev_rd_b = 1'b0;
  int         n_tests = 0, n_fail = 0;

  // Monitor: values seen at an edge belong to the cycle that edge closes, stamped with cyc.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_read_a) begin
      rd_cnt_a <= rd_cnt_a + 1;
      rdc_a.push_back(cyc);
      if (rxq_a.size() > 0) void'(rxq_a.pop_front());
    end
    if (rx_read_b) begin
      rd_cnt_b <= rd_cnt_b + 1;
      if (rxq_b.size() > 0) void'(rxq_b.pop_front());
    end
    if (tx_write_a) begin
      txq_a.push_back(tx_data_a);
      wrc_a.push_back(cyc);
    end
    if (tx_write_b) txq_b.push_back(tx_data_b);
    if ((tx_write_a && prev_wr_a) || (rx_read_a && prev_rd_a) ||
        (tx_write_b && prev_wr_b) || (rx_read_b && prev_rd_b)) b2b_err <= b2b_err + 1;
    prev_wr_a <= tx_write_a;
    prev_rd_a <= rx_read_a;
    prev_wr_b <= tx_write_b;
    prev_rd_b <= rx_read_b;
  end

  // rx FIFO model outputs refresh mid-cycle, after pops and bench pushes.
  always @(negedge clk) begin
    rx_empty_a <= (rxq_a.size() == 0);
    rx_data_a  <= (rxq_a.size() != 0) ? rxq_a[0] : 8'h00;
    rx_empty_b <= (rxq_b.size() == 0);
    rx_data_b  <= (rxq_b.size() != 0) ? rxq_b[0] : 8'h00;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // Reference: what the echo service should push for one received word.
  task automatic model_push(input logic [7:0] w, input bit up, input bit crlf);
    if (up && w >= 8'h61 && w <= 8'h7A) exp_q.push_back(w - 8'h20);
    else exp_q.push_back(w);
    if (crlf && w == 8'h0D) exp_q.push_back(8'h0A);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    tx_full_a = 1'b0;
    tx_full_b = 1'b0;
    enable    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int sel, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && txq_a.size() >= n) || (sel == 1 && txq_b.size() >= n)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int base_rd, base_tx;
    bit ok;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rx_read_a, tx_write_a, busy_a} !== 3'b000 || echo_count_a !== 16'h0 ||
        tx_data_a !== 8'h00)
      $display("FAIL reset_values: rd=%b wr=%b busy=%b cnt=%0d data=%h, want all 0",
               rx_read_a, tx_write_a, busy_a, echo_count_a, tx_data_a);
    rst_n = 1'b1;
    @(negedge clk);
    base_tx = txq_a.size();
    @(posedge clk);
    #1 rxq_a.push_back(8'h55);
    wait_tx(0, base_tx + 1, 20, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_first_echo: no push seen, want 1 push");
    end
    repeat (3) @(negedge clk);
    base_rd = rd_cnt_a;
    base_tx = txq_a.size();
    @(posedge clk);
    #1 rxq_a.push_back(8'h33);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_cnt_a == base_rd + 1) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup: popped=%b busy=%b, want 1 1", ok, busy_a);
    end
    // Now in the write state with a push due at the next edge.
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rx_read_a, tx_write_a, busy_a} !== 3'b000 || echo_count_a !== 16'h0 ||
        tx_data_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: rd=%b wr=%b busy=%b cnt=%0d data=%h, want all 0",
               rx_read_a, tx_write_a, busy_a, echo_count_a, tx_data_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (txq_a.size() != base_tx || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_push: pushes=%0d busy=%b, want 0 0", txq_a.size() - base_tx,
               busy_a);
    end
  endtask

  task automatic test_single();
    int base_rd, base_wr, base_tx, k;
    bit ok;
    do_reset();
    base_rd = rdc_a.size();
    base_wr = wrc_a.size();
    base_tx = txq_a.size();
    @(posedge clk);
    #1 rxq_a.push_back(8'h41);
    k = cyc;
    wait_tx(0, base_tx + 1, 20, ok);
    repeat (4) @(negedge clk);
    n_tests++;
    if (!ok || txq_a[base_tx] !== 8'h41) begin
      n_fail++;
      $display("FAIL single_data: got=%h, want 41", ok ? txq_a[base_tx] : 8'hxx);
    end
    n_tests++;
    if (rdc_a.size() - base_rd != 1 || rdc_a[base_rd] != k + 1) begin
      n_fail++;
      $display("FAIL single_rx_read: pulses=%0d cycle=%0d, want 1 at %0d",
               rdc_a.size() - base_rd, rdc_a.size() > base_rd ? rdc_a[base_rd] : -1, k + 1);
    end
    n_tests++;
    if (wrc_a.size() - base_wr != 1 || wrc_a[base_wr] != k + 3) begin
      n_fail++;
      $display("FAIL single_latency: pushes=%0d cycle=%0d, want 1 at %0d",
               wrc_a.size() - base_wr, wrc_a.size() > base_wr ? wrc_a[base_wr] : -1, k + 3);
    end
    n_tests++;
    if (echo_count_a !== 16'd1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_count: cnt=%0d busy=%b, want 1 0", echo_count_a, busy_a);
    end
  endtask

  task automatic test_crlf();
    int base_wr, base_tx, base_txb;
    bit ok_a, ok_b;
    do_reset();
    base_wr  = wrc_a.size();
    base_tx  = txq_a.size();
    base_txb = txq_b.size();
    @(posedge clk);
    #1;
    rxq_a.push_back(8'h0D);
    rxq_b.push_back(8'h0D);
    wait_tx(0, base_tx + 2, 30, ok_a);
    wait_tx(1, base_txb + 1, 30, ok_b);
    repeat (10) @(negedge clk);
    n_tests++;
    if (!ok_a || txq_a.size() != base_tx + 2 || txq_a[base_tx] !== 8'h0D ||
        txq_a[base_tx+1] !== 8'h0A) begin
      n_fail++;
      $display("FAIL crlf_seq: pushes=%0d, want 2 (0d 0a)", txq_a.size() - base_tx);
    end
    n_tests++;
    if (!ok_a || wrc_a[base_wr+1] - wrc_a[base_wr] != 2) begin
      n_fail++;
      $display("FAIL crlf_spacing: gap=%0d, want 2",
               ok_a ? wrc_a[base_wr+1] - wrc_a[base_wr] : -1);
    end
    n_tests++;
    if (echo_count_a !== 16'd2) begin
      n_fail++;
      $display("FAIL crlf_count: cnt=%0d, want 2", echo_count_a);
    end
    n_tests++;
    if (!ok_b || txq_b.size() != base_txb + 1 || txq_b[base_txb] !== 8'h0D ||
        echo_count_b !== 3'd1) begin
      n_fail++;
      $display("FAIL crlf_off: pushes=%0d cnt=%0d, want 1 push of 0d and 1",
               txq_b.size() - base_txb, echo_count_b);
    end
  endtask

  task automatic test_backpressure();
    int base_rd, base_tx;
    bit ok;
    do_reset();
    tx_full_a = 1'b1;
    base_rd = rd_cnt_a;
    base_tx = txq_a.size();
    @(posedge clk);
    #1;
    rxq_a.push_back(8'h62);
    rxq_a.push_back(8'h63);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_cnt_a == base_rd + 1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (50) @(negedge clk);
    n_tests++;
    if (!ok || txq_a.size() != base_tx || rd_cnt_a != base_rd + 1 || tx_data_a !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_hold: pushes=%0d pops=%0d data=%h, want 0 1 00",
               txq_a.size() - base_tx, rd_cnt_a - base_rd, tx_data_a);
    end
    tx_full_a = 1'b0;
    wait_tx(0, base_tx + 1, 10, ok);
    n_tests++;
    if (!ok || txq_a[base_tx] !== 8'h42 || rd_cnt_a != base_rd + 1) begin
      n_fail++;
      $display("FAIL bp_release: got=%h pops=%0d, want 42 1",
               ok ? txq_a[base_tx] : 8'hxx, rd_cnt_a - base_rd);
    end
    wait_tx(0, base_tx + 2, 20, ok);
    n_tests++;
    if (!ok || txq_a[base_tx+1] !== 8'h43) begin
      n_fail++;
      $display("FAIL bp_next: got=%h, want 43", ok ? txq_a[base_tx+1] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int base_rd, base_tx, nerr;
    logic [7:0] w;
    bit ok;
    do_reset();
    exp_q.delete();
    base_rd = rd_cnt_a;
    base_tx = txq_a.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) w = 8'h0D;
      else if (i % 3 == 0) w = 8'(8'h61 + $urandom_range(0, 25));
      else w = 8'($urandom_range(0, 255));
      rxq_a.push_back(w);
      model_push(w, 1'b1, 1'b1);
    end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      tx_full_a = ($urandom_range(0, 3) == 0);
      if (txq_a.size() >= base_tx + exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    tx_full_a = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (!ok || txq_a.size() != base_tx + exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_len: pushes=%0d, want %0d", txq_a.size() - base_tx, exp_q.size());
    end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && base_tx + i < txq_a.size(); i++) begin
      n_tests++;
      if (txq_a[base_tx+i] !== exp_q[i]) begin
        n_fail++;
        nerr++;
        if (nerr < 5)
          $display("FAIL b2b_data[%0d]: got=%h, want %h", i, txq_a[base_tx+i], exp_q[i]);
      end
    end
    n_tests++;
    if (echo_count_a !== 16'(exp_q.size()) || rd_cnt_a - base_rd != 30) begin
      n_fail++;
      $display("FAIL b2b_count: cnt=%0d pops=%0d, want %0d 30", echo_count_a,
               rd_cnt_a - base_rd, exp_q.size());
    end
    n_tests++;
    if (b2b_err != 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: adjacent pulses=%0d, want 0", b2b_err);
    end
  endtask

  task automatic test_saturation();
    int base_tx;
    logic [7:0] words[9];
    bit ok;
    do_reset();
    base_tx = txq_b.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      words[i] = 8'($urandom_range(0, 255));
      rxq_b.push_back(words[i]);
    end
    wait_tx(1, base_tx + 7, 200, ok);
    repeat (3) @(negedge clk);
    n_tests++;
    if (!ok || echo_count_b !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_reach: cnt=%0d, want 7", echo_count_b);
    end
    wait_tx(1, base_tx + 9, 200, ok);
    repeat (5) @(negedge clk);
    n_tests++;
    if (!ok || echo_count_b !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%0d, want 7", echo_count_b);
    end
    for (int i = 0; i < 9 && base_tx + i < txq_b.size(); i++) begin
      n_tests++;
      if (txq_b[base_tx+i] !== words[i]) begin
        n_fail++;
        $display("FAIL sat_data[%0d]: got=%h, want %h", i, txq_b[base_tx+i], words[i]);
      end
    end
  endtask

  task automatic test_stream_enable();
    int base_rd, base_tx;
    logic [7:0] w;
    bit ok;
    do_reset();
    exp_q.delete();
    base_rd = rd_cnt_a;
    base_tx = txq_a.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom_range(0, 255));
      rxq_a.push_back(w);
      if (i < 3) model_push(w, 1'b1, 1'b1);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_cnt_a == base_rd + 3) begin
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++;
    if (!ok || rd_cnt_a - base_rd != 3 || rxq_a.size() != 7) begin
      n_fail++;
      $display("FAIL stream_pops: pops=%0d left=%0d, want 3 7", rd_cnt_a - base_rd,
               rxq_a.size());
    end
    n_tests++;
    if (txq_a.size() - base_tx != exp_q.size()) begin
      n_fail++;
      $display("FAIL stream_len: pushes=%0d, want %0d", txq_a.size() - base_tx, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base_tx + i < txq_a.size(); i++) begin
      n_tests++;
      if (txq_a[base_tx+i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream_data[%0d]: got=%h, want %h", i, txq_a[base_tx+i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_crlf();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_stream_enable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
